dmem_responder: RTL

- Memory-side responder for the pipeline's data-memory port.
- Accepts one word-addressed read or write request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then returns the result on a valid/ready response channel.
- The MEM stage uses `busy` / `req_ready` to stall, so the pipeline can be verified against a multi-cycle memory instead of a zero-latency array.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word width
// and wait-state limits.
package mips_mem_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to count down from max_val to zero, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: synchronous write, combinational read on one index.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Store the write word at the access edge.
  // NOTE: the array has no reset; clearing every word would need a reset fan-out
  // to all storage bits and keep it from mapping onto RAM, and software never
  // relies on memory being zero.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding word access, a fixed
// number of wait states, then a held response until the requester takes it.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  acc_count
);

  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
  localparam int WCNT_W   = cnt_width(WAIT_EFF);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_EFF);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [WORD_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [CNT_W-1:0]    r_acc_count;

  logic                w_req_fire;
  logic                w_rsp_fire;
  logic                w_access;
  logic                w_in_range;
  logic                w_mem_we;
  logic [IDX_W-1:0]    w_idx;
  logic [WORD_W-1:0]   w_mem_rdata;

  assign w_req_fire = (r_state == IDLE) && req_valid;
  assign w_access   = (r_state == WAIT) && (r_wcnt == '0);
  assign w_rsp_fire = (r_state == RESP) && rsp_ready;
  // Full-width compare so upper address bits can flag an error.
  assign w_in_range = (64'(r_addr) < 64'(DEPTH));
  assign w_idx      = r_addr[IDX_W-1:0];
  assign w_mem_we   = w_access && r_write && w_in_range;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: accept, count down, then hold the response.
  always_comb begin
    // NOTE: default first so no path through the case leaves it unassigned
    // and infers a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req_fire) w_state_nxt = WAIT;
      WAIT:    if (w_access)   w_state_nxt = RESP;
      RESP:    if (w_rsp_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the request at acceptance; later request activity is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_req_fire) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Wait-state counter: loaded at acceptance, the access happens once it is zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (w_req_fire) begin
      r_wcnt <= WAIT_LOAD;
    end else if ((r_state == WAIT) && (r_wcnt != '0)) begin
      r_wcnt <= r_wcnt - 1'b1;
    end
  end

  // Response payload: set at the access edge, cleared at the response handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_access) begin
      r_rsp_rdata <= (!r_write && w_in_range) ? w_mem_rdata : '0;
      r_rsp_err   <= !w_in_range;
    end else if (w_rsp_fire) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end
  end

  // Completed-access counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_acc_count <= '0;
    else if (w_rsp_fire) r_acc_count <= r_acc_count + 1'b1;
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign acc_count = r_acc_count;

endmodule
